// File: rtl/mbox_arb_pkg.sv
// rtl/mbox_arb_pkg.sv - shared types and helpers for the MBOX cycle arbiter
package mbox_arb_pkg;

    localparam int REQ_CCA  = 0;
    localparam int REQ_CHAN = 1;
    localparam int REQ_EBOX = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ERR     = 2'd2,
        PF_HOLD = 2'd3
    } tArbState;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_CSH_ADR_PAR = 3'd1,
        ERR_MB_PAR      = 3'd2,
        ERR_ADR_PAR     = 3'd3,
        ERR_NXM         = 3'd4,
        ERR_SBUS        = 3'd5
    } tMboxErr;

    // Simultaneous errors report the lowest code.
    function automatic tMboxErr pick_err(input logic csh, input logic mb,
                                         input logic adr, input logic sbus);
        if (csh)       return ERR_CSH_ADR_PAR;
        else if (mb)   return ERR_MB_PAR;
        else if (adr)  return ERR_ADR_PAR;
        else if (sbus) return ERR_SBUS;
        else           return ERR_NONE;
    endfunction

endpackage

// File: rtl/mbox_prio_pick.sv
// rtl/mbox_prio_pick.sv - fixed-priority one-hot pick with EBOX starvation override
module mbox_prio_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic             forceEbox,
    output logic [N_REQ-1:0] win
);

    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        if (forceEbox && req[N_REQ-1]) begin
            win[N_REQ-1] = 1'b1;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && !found) begin
                    win[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mbox_cycle_arb.sv
// rtl/mbox_cycle_arb.sv - MBOX cycle arbiter: grant, start, await response/error/page fail/NXM
module mbox_cycle_arb #(
    parameter int N_REQ        = 3,
    parameter int RESP_TIMEOUT = 64,
    parameter int STARVE_MAX   = 4
) (
    input  logic             clk,
    input  logic             CROBAR,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             memStart,
    input  logic             memResp,
    input  logic             pfEboxHandle,
    input  logic             cshAdrParErr,
    input  logic             mbParErr,
    input  logic             adrParErr,
    input  logic             sbusErr,
    input  logic             errAck,
    input  logic             pfClr,
    output logic [N_REQ-1:0] done,
    output logic             errValid,
    output logic [2:0]       errCode,
    output logic             pageFailHold,
    output logic             eboxRetryReq,
    output logic             busy
);
    import mbox_arb_pkg::*;

    localparam int TW   = $clog2(RESP_TIMEOUT + 1);
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int EBOX = N_REQ - 1;

    tArbState         state, state_n;
    logic [N_REQ-1:0] grant_n, done_n, win;
    logic             mem_start_n, err_valid_n, pf_hold_n, retry_n;
    logic [2:0]       err_code_n;
    logic [TW-1:0]    timer, timer_n;
    logic [SW-1:0]    starve_cnt, starve_n;
    logic             any_err;

    assign any_err = cshAdrParErr | mbParErr | adrParErr | sbusErr;
    assign busy    = (state != IDLE);

    mbox_prio_pick #(.N_REQ(N_REQ)) u_pick (
        .req       (req),
        .forceEbox (starve_cnt == SW'(STARVE_MAX)),
        .win       (win)
    );

    // In IDLE a nonzero grant means arbitration already happened; the next edge starts the cycle.
    always_comb begin
        state_n     = state;
        grant_n     = grant;
        mem_start_n = 1'b0;
        done_n      = '0;
        err_valid_n = errValid;
        err_code_n  = errCode;
        pf_hold_n   = pageFailHold;
        retry_n     = 1'b0;
        timer_n     = timer;
        starve_n    = starve_cnt;
        case (state)
            IDLE: begin
                if (grant != '0) begin
                    state_n     = BUSY;
                    mem_start_n = 1'b1;
                    timer_n     = '0;
                end else if ((|req) && !errValid) begin
                    grant_n = win;
                    if (!req[EBOX] || win[EBOX])
                        starve_n = '0;
                    else if (starve_cnt != SW'(STARVE_MAX))
                        starve_n = starve_cnt + SW'(1);
                end
            end
            BUSY: begin
                timer_n = timer + TW'(1);
                if (any_err) begin
                    err_valid_n = 1'b1;
                    err_code_n  = pick_err(cshAdrParErr, mbParErr, adrParErr, sbusErr);
                    grant_n     = '0;
                    state_n     = ERR;
                end else if (pfEboxHandle && grant[EBOX]) begin
                    pf_hold_n = 1'b1;
                    grant_n   = '0;
                    state_n   = PF_HOLD;
                end else if (memResp) begin
                    done_n  = grant;
                    grant_n = '0;
                    state_n = IDLE;
                end else if (timer == TW'(RESP_TIMEOUT - 1)) begin
                    err_valid_n = 1'b1;
                    err_code_n  = ERR_NXM;
                    grant_n     = '0;
                    state_n     = ERR;
                end
            end
            ERR: begin
                if (errAck) begin
                    err_valid_n = 1'b0;
                    err_code_n  = ERR_NONE;
                    state_n     = IDLE;
                end
            end
            PF_HOLD: begin
                if (pfClr) begin
                    pf_hold_n = 1'b0;
                    retry_n   = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state        <= IDLE;
            grant        <= '0;
            memStart     <= 1'b0;
            done         <= '0;
            errValid     <= 1'b0;
            errCode      <= ERR_NONE;
            pageFailHold <= 1'b0;
            eboxRetryReq <= 1'b0;
            timer        <= '0;
            starve_cnt   <= '0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            memStart     <= mem_start_n;
            done         <= done_n;
            errValid     <= err_valid_n;
            errCode      <= err_code_n;
            pageFailHold <= pf_hold_n;
            eboxRetryReq <= retry_n;
            timer        <= timer_n;
            starve_cnt   <= starve_n;
        end
    end

endmodule

// File: tb/tb_mbox_cycle_arb.sv
// tb/tb_mbox_cycle_arb.sv - self-checking bench for mbox_cycle_arb
module tb_mbox_cycle_arb;

    logic       clk = 1'b0;
    logic       CROBAR = 1'b1;
    logic [2:0] req = '0;
    logic       memResp = 0, pfEboxHandle = 0, cshAdrParErr = 0, mbParErr = 0;
    logic       adrParErr = 0, sbusErr = 0, errAck = 0, pfClr = 0;
    logic [2:0] grant, done, errCode;
    logic       memStart, errValid, pageFailHold, eboxRetryReq, busy;

    int total  = 0;
    int passed = 0;
    int losses = 0;

    always #5 clk = ~clk;

    mbox_cycle_arb dut (
        .clk(clk), .CROBAR(CROBAR), .req(req), .grant(grant), .memStart(memStart),
        .memResp(memResp), .pfEboxHandle(pfEboxHandle), .cshAdrParErr(cshAdrParErr),
        .mbParErr(mbParErr), .adrParErr(adrParErr), .sbusErr(sbusErr), .errAck(errAck),
        .pfClr(pfClr), .done(done), .errValid(errValid), .errCode(errCode),
        .pageFailHold(pageFailHold), .eboxRetryReq(eboxRetryReq), .busy(busy)
    );

    typedef struct {
        logic [2:0] rq;
        logic [5:0] ev;    // {sbus, adr, mb, csh, pf, memResp}
        logic [2:0] g;
        logic [2:0] d;
        logic [2:0] code;
        logic       pfh;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_ev(input logic [5:0] ev);
        memResp      = ev[0];
        pfEboxHandle = ev[1];
        cshAdrParErr = ev[2];
        mbParErr     = ev[3];
        adrParErr    = ev[4];
        sbusErr      = ev[5];
    endtask

    task automatic do_reset();
        req = '0;
        apply_ev('0);
        CROBAR = 1'b1;
        step();
        CROBAR = 1'b0;
        losses = 0;
        step();
    endtask

    // Reference arbitration: priority by index, EBOX forced after four straight losses.
    task automatic model_pick(input logic [2:0] r, output logic [2:0] w);
        if (r[2] && (losses >= 4 || r[1:0] == 2'b00)) begin
            w = 3'b100;
            losses = 0;
        end else begin
            w = r[0] ? 3'b001 : 3'b010;
            if (r[2]) losses = (losses + 1 > 4) ? 4 : losses + 1;
            else      losses = 0;
        end
    endtask

    function automatic logic [2:0] lowest_code(input logic [3:0] m);
        if (m[0])      return 3'd1;
        else if (m[1]) return 3'd2;
        else if (m[2]) return 3'd3;
        else if (m[3]) return 3'd5;
        else           return 3'd0;
    endfunction

    // Checks the registered outcome of a cycle, then walks the DUT back to IDLE.
    task automatic settle(input string tag, input logic [2:0] ed, input logic [2:0] ec, input logic ep);
        chk({tag, "_done"}, done, ed);
        chk({tag, "_errValid"}, errValid, (ec != 0));
        chk({tag, "_errCode"}, errCode, ec);
        chk({tag, "_pfHold"}, pageFailHold, ep);
        chk({tag, "_grant_drop"}, grant, 0);
        if (ec != 0) begin
            errAck = 1; step(); errAck = 0;
            chk({tag, "_ack_clr"}, {errValid, errCode, busy}, 0);
        end else if (ep) begin
            pfClr = 1; step(); pfClr = 0;
            chk({tag, "_retry"}, {eboxRetryReq, pageFailHold, busy}, 3'b100);
            step();
            chk({tag, "_retry_once"}, eboxRetryReq, 0);
        end else begin
            step();
            chk({tag, "_done_once"}, done, 0);
        end
    endtask

    task automatic do_cycle(input logic [2:0] r, input logic [2:0] eg, input string tag);
        req = r; step();
        chk({tag, "_grant"}, grant, eg);
        step();
        chk({tag, "_memStart"}, memStart, 1);
        memResp = 1; req = 0; step(); memResp = 0;
        chk({tag, "_done"}, done, eg);
    endtask

    task automatic reset_probe(input string tag);
        #2 CROBAR = 1'b1;
        #1 chk({tag, "_async_clear"},
               {grant, memStart, done, errValid, errCode, pageFailHold, eboxRetryReq, busy}, 0);
        req = 3'b100;
        apply_ev('0);
        step();
        CROBAR = 1'b0;
        step();
        chk({tag, "_post_grant"}, grant, 3'b100);
        do_reset();
    endtask

    always @(negedge clk) begin
        if (!CROBAR) begin
            chk("grant_onehot", $onehot0(grant), 1);
            chk("done_grant_excl", (done != 0 && grant != 0 && done != grant), 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        logic [2:0] sreq[10];
        logic [2:0] sexp[10];
        logic [2:0] r, eg, ec, ed;
        logic [3:0] mask;
        logic       mr, ep;
        int         kind, d, seen;

        vt[0] = '{3'b111, 6'b000001, 3'b001, 3'b001, 3'd0, 1'b0};
        vt[1] = '{3'b110, 6'b000001, 3'b010, 3'b010, 3'd0, 1'b0};
        vt[2] = '{3'b100, 6'b101000, 3'b100, 3'b000, 3'd2, 1'b0};
        vt[3] = '{3'b100, 6'b000011, 3'b100, 3'b000, 3'd0, 1'b1};
        vt[4] = '{3'b010, 6'b000011, 3'b010, 3'b010, 3'd0, 1'b0};
        vt[5] = '{3'b011, 6'b011101, 3'b001, 3'b000, 3'd1, 1'b0};
        vt[6] = '{3'b001, 6'b010000, 3'b001, 3'b000, 3'd3, 1'b0};
        vt[7] = '{3'b001, 6'b100000, 3'b001, 3'b000, 3'd5, 1'b0};
        vt[8] = '{3'b101, 6'b100001, 3'b001, 3'b000, 3'd5, 1'b0};

        step(); step();
        chk("reset_outputs",
            {grant, memStart, done, errValid, errCode, pageFailHold, eboxRetryReq, busy}, 0);
        CROBAR = 1'b0;
        step();
        chk("idle_no_req", {grant, busy}, 0);

        for (int i = 0; i < 9; i++) begin
            req = vt[i].rq; step();
            chk($sformatf("vec%0d_grant", i), grant, vt[i].g);
            chk($sformatf("vec%0d_no_start_yet", i), memStart, 0);
            step();
            chk($sformatf("vec%0d_start", i), {memStart, busy}, 2'b11);
            apply_ev(vt[i].ev); req = 0; step(); apply_ev('0);
            settle($sformatf("vec%0d", i), vt[i].d, vt[i].code, vt[i].pfh);
        end

        // EBOX starvation: forced win after four losses, then the count starts over.
        do_reset();
        sreq = '{3'b101, 3'b110, 3'b101, 3'b110, 3'b101, 3'b111, 3'b110, 3'b101, 3'b110, 3'b101};
        sexp = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 10; i++) do_cycle(sreq[i], sexp[i], $sformatf("starve%0d", i));
        step();

        // Page fail beats memResp; errAck ignored in PF_HOLD; pfClr five cycles later.
        req = 3'b100; step(); step();
        pfEboxHandle = 1; memResp = 1; req = 0; step(); apply_ev('0);
        chk("pf_hold_set", {pageFailHold, busy, done, grant}, 8'b11000000);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            errAck = (i == 1);
            step();
            if (!pageFailHold || eboxRetryReq) seen++;
        end
        errAck = 0;
        chk("pf_hold_steady", seen, 0);
        pfClr = 1; step(); pfClr = 0;
        chk("pf_retry_pulse", {eboxRetryReq, pageFailHold, busy}, 3'b100);
        step();
        chk("pf_retry_single", eboxRetryReq, 0);

        // NXM after 64 BUSY cycles; pending request waits for errAck.
        req = 3'b010; step(); step();
        chk("nxm_start", memStart, 1);
        seen = 0;
        for (int i = 0; i < 63; i++) begin step(); if (errValid) seen++; end
        chk("nxm_not_early", seen, 0);
        step();
        chk("nxm_flag", {errValid, errCode}, 4'b1100);
        step(); step(); step();
        chk("nxm_no_grant", grant, 0);
        errAck = 1; step(); errAck = 0;
        chk("nxm_ack", {errValid, errCode, busy}, 0);
        step();
        chk("nxm_regrant", grant, 3'b010);
        step();
        memResp = 1; req = 0; step(); memResp = 0;
        chk("nxm_regrant_done", done, 3'b010);

        // memResp on the final timeout cycle completes normally.
        req = 3'b001; step(); step();
        for (int i = 0; i < 63; i++) step();
        memResp = 1; req = 0; step(); memResp = 0;
        chk("nxm_edge_resp", {done, errValid}, 4'b0010);
        step();

        // Asynchronous reset from BUSY, ERR and PF_HOLD.
        req = 3'b010; step(); step();
        reset_probe("rst_busy");
        req = 3'b001; step(); step();
        sbusErr = 1; req = 0; step(); sbusErr = 0;
        chk("rst_err_entry", errValid, 1);
        reset_probe("rst_err");
        req = 3'b100; step(); step();
        pfEboxHandle = 1; req = 0; step(); pfEboxHandle = 0;
        chk("rst_pf_entry", pageFailHold, 1);
        reset_probe("rst_pf");

        // Randomized transactions against the reference model.
        for (int it = 0; it < 150; it++) begin
            r = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 1) == 1) r[2] = 1'b1;
            model_pick(r, eg);
            req = r; step();
            chk("rnd_grant", grant, eg);
            step();
            chk("rnd_start", memStart, 1);
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin req = 3'($urandom_range(0, 7)); step(); end
            req = 0;
            kind = $urandom_range(0, 19);
            ed = 0; ec = 0; ep = 0;
            if (kind == 0) begin
                for (int k = 0; k < 63 - d; k++) step();
                step();
                ec = 3'd4;
            end else if (kind <= 6) begin
                mask = 4'($urandom_range(1, 15));
                mr = 1'($urandom_range(0, 1));
                apply_ev({mask, 1'($urandom_range(0, 1)), mr});
                step(); apply_ev('0);
                ec = lowest_code(mask);
            end else if (kind <= 10) begin
                mr = 1'($urandom_range(0, 1));
                apply_ev({4'b0000, 1'b1, mr});
                step(); apply_ev('0);
                if (eg == 3'b100) ep = 1;
                else if (mr) ed = eg;
                else begin
                    chk("rnd_pf_ignored", {busy, done}, 4'b1000);
                    memResp = 1; step(); memResp = 0;
                    ed = eg;
                end
            end else begin
                memResp = 1; step(); memResp = 0;
                ed = eg;
            end
            settle("rnd", ed, ec, ep);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
